// File: rtl/esc_bank.sv
// rtl/esc_bank.sv - four-channel ESC pulse generator with arming sequence and per-frame slew limit
module esc_bank #(
    parameter int         PERIOD_W   = 17,
    parameter int         MIN_PULSE  = 50000,
    parameter int         ARM_FRAMES = 16,
    parameter int         SLEW       = 64,
    parameter logic [9:0] OFF_FRNT   = 10'd0,
    parameter logic [9:0] OFF_BCK    = 10'd0,
    parameter logic [9:0] OFF_LFT    = 10'd0,
    parameter logic [9:0] OFF_RGHT   = 10'd0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        arm,
    input  logic [10:0] frnt_spd,
    input  logic [10:0] bck_spd,
    input  logic [10:0] lft_spd,
    input  logic [10:0] rght_spd,
    output logic        frnt,
    output logic        bck,
    output logic        lft,
    output logic        rght,
    output logic        armed,
    output logic        frm_strb
);

    localparam int ACW = $clog2(ARM_FRAMES + 1);
    localparam logic signed [11:0] SLEW_S = 12'(SLEW);
    localparam logic [9:0] OFFS [4] = '{OFF_FRNT, OFF_BCK, OFF_LFT, OFF_RGHT};

    typedef enum logic [1:0] {IDLE, ARMING, RUN} state_t;

    state_t              state, state_nxt;
    logic [PERIOD_W-1:0] cnt, cnt_nxt;
    logic [ACW-1:0]      arm_cnt, arm_cnt_nxt;
    logic [10:0]         tgt [4];
    logic [10:0]         app [4];
    logic [10:0]         app_nxt [4];
    logic [3:0]          pwm, pwm_nxt;
    logic                live, live_nxt;
    logic                frame_end;

    function automatic logic [10:0] slew_step(input logic [10:0] t, input logic [10:0] a);
        logic signed [11:0] d;
        d = $signed({1'b0, t}) - $signed({1'b0, a});
        if (d <= SLEW_S && d >= -SLEW_S)
            return t;
        else if (d > 12'sd0)
            return a + 11'(SLEW);
        else
            return a - 11'(SLEW);
    endfunction

    function automatic logic [31:0] pulse_w(input logic [10:0] a, input logic [9:0] o);
        return 32'(MIN_PULSE) + 32'(a) * 32'd3 + 32'(o);
    endfunction

    assign tgt[0] = frnt_spd;
    assign tgt[1] = bck_spd;
    assign tgt[2] = lft_spd;
    assign tgt[3] = rght_spd;

    always_comb begin
        cnt_nxt     = cnt + 1'b1;
        frame_end   = &cnt;
        // Outputs stay quiet until the first full frame after reset so no partial pulse escapes.
        live_nxt    = live | frame_end;
        state_nxt   = state;
        arm_cnt_nxt = arm_cnt;
        for (int i = 0; i < 4; i++) app_nxt[i] = app[i];

        if (frame_end) begin
            case (state)
                IDLE: begin
                    for (int i = 0; i < 4; i++) app_nxt[i] = '0;
                    if (arm) begin
                        state_nxt   = ARMING;
                        arm_cnt_nxt = ACW'(1);
                    end
                end
                ARMING: begin
                    for (int i = 0; i < 4; i++) app_nxt[i] = '0;
                    if (!arm) begin
                        state_nxt   = IDLE;
                        arm_cnt_nxt = '0;
                    end else if (arm_cnt == ACW'(ARM_FRAMES)) begin
                        state_nxt   = RUN;
                        arm_cnt_nxt = '0;
                    end else begin
                        arm_cnt_nxt = arm_cnt + 1'b1;
                    end
                end
                RUN: begin
                    if (!arm) begin
                        state_nxt = IDLE;
                        for (int i = 0; i < 4; i++) app_nxt[i] = '0;
                    end else begin
                        for (int i = 0; i < 4; i++) app_nxt[i] = slew_step(tgt[i], app[i]);
                    end
                end
                default: begin
                    state_nxt   = IDLE;
                    arm_cnt_nxt = '0;
                    for (int i = 0; i < 4; i++) app_nxt[i] = '0;
                end
            endcase
        end

        // Pulse is judged against the counter and speed of the next cycle so the output is registered.
        for (int i = 0; i < 4; i++)
            pwm_nxt[i] = live_nxt && (32'(cnt_nxt) < pulse_w(app_nxt[i], OFFS[i]));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            state    <= IDLE;
            arm_cnt  <= '0;
            for (int i = 0; i < 4; i++) app[i] <= '0;
            pwm      <= '0;
            live     <= 1'b0;
            armed    <= 1'b0;
            frm_strb <= 1'b0;
        end else begin
            cnt      <= cnt_nxt;
            state    <= state_nxt;
            arm_cnt  <= arm_cnt_nxt;
            for (int i = 0; i < 4; i++) app[i] <= app_nxt[i];
            pwm      <= pwm_nxt;
            live     <= live_nxt;
            armed    <= (state_nxt == RUN);
            frm_strb <= frame_end;
        end
    end

    assign frnt = pwm[0];
    assign bck  = pwm[1];
    assign lft  = pwm[2];
    assign rght = pwm[3];

endmodule

// File: tb/tb_esc_bank.sv
// tb/tb_esc_bank.sv - directed frame-by-frame check of esc_bank with a shortened frame
module tb_esc_bank;

    localparam int FRAME = 1024;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        arm = 1'b0;
    logic [10:0] frnt_spd = '0;
    logic [10:0] bck_spd = '0;
    logic [10:0] lft_spd = '0;
    logic [10:0] rght_spd = '0;
    logic        frnt, bck, lft, rght, armed, frm_strb;

    int checks = 0;
    int failures = 0;

    esc_bank #(
        .PERIOD_W(10), .MIN_PULSE(100), .ARM_FRAMES(4), .SLEW(64),
        .OFF_FRNT(10'd0), .OFF_BCK(10'd7), .OFF_LFT(10'd0), .OFF_RGHT(10'd2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .arm(arm),
        .frnt_spd(frnt_spd), .bck_spd(bck_spd), .lft_spd(lft_spd), .rght_spd(rght_spd),
        .frnt(frnt), .bck(bck), .lft(lft), .rght(rght),
        .armed(armed), .frm_strb(frm_strb)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // After reset release the first strobe must come only after a full counter wrap.
    task automatic wait_first_strobe(input string tag);
        int n;
        int highs;
        n = 0;
        highs = 0;
        while (!frm_strb && n < 2 * FRAME) begin
            highs += int'(frnt) + int'(bck) + int'(lft) + int'(rght) + int'(armed);
            @(negedge clk);
            n++;
        end
        check({tag, "_wait"}, n, FRAME);
        check({tag, "_quiet"}, highs, 0);
    endtask

    // Measures one frame starting at a strobe cycle; optional mid-frame input changes.
    task automatic frame_chk(input string tag, input int ef, input int eb, input int el, input int er,
                             input int earm, input int chg_at, input logic chg_arm,
                             input logic [10:0] chg_frnt, input int chg2_at, input logic chg2_arm);
        int w [4];
        int rises;
        int strb;
        int armed_s;
        logic [3:0] cur;
        logic [3:0] prev;
        check({tag, "_strb0"}, int'(frm_strb), 1);
        armed_s = int'(armed);
        for (int k = 0; k < 4; k++) w[k] = 0;
        rises = 0;
        strb = 0;
        prev = 4'b1111;
        for (int i = 0; i < FRAME; i++) begin
            if (i == chg_at) begin
                arm = chg_arm;
                frnt_spd = chg_frnt;
            end
            if (i == chg2_at) arm = chg2_arm;
            cur = {rght, lft, bck, frnt};
            for (int k = 0; k < 4; k++) begin
                if (cur[k]) w[k]++;
                if (cur[k] && !prev[k]) rises++;
            end
            strb += int'(frm_strb);
            prev = cur;
            @(negedge clk);
        end
        check({tag, "_frnt"}, w[0], ef);
        check({tag, "_bck"}, w[1], eb);
        check({tag, "_lft"}, w[2], el);
        check({tag, "_rght"}, w[3], er);
        check({tag, "_armed"}, armed_s, earm);
        check({tag, "_rises"}, rises, 0);
        check({tag, "_nstrb"}, strb, 1);
    endtask

    task automatic idle_frame(input string tag, input int earm);
        frame_chk(tag, 100, 107, 100, 102, earm, -1, 1'b0, 11'd0, -1, 1'b0);
    endtask

    task automatic plain_frame(input string tag, input int ef, input int eb, input int el,
                               input int er, input int earm);
        frame_chk(tag, ef, eb, el, er, earm, -1, 1'b0, 11'd0, -1, 1'b0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("reset_outs", int'({frnt, bck, lft, rght, armed, frm_strb}), 0);
        rst_n = 1'b1;
        wait_first_strobe("boot");

        for (int f = 0; f < 3; f++) idle_frame($sformatf("idle%0d", f), 0);

        arm = 1'b1;
        frnt_spd = 11'd256;
        bck_spd = 11'd100;
        lft_spd = 11'd30;
        rght_spd = 11'd0;
        idle_frame("arm_sample", 0);
        for (int f = 0; f < 4; f++) idle_frame($sformatf("arming%0d", f), 0);
        idle_frame("run0", 1);
        plain_frame("run1", 292, 299, 190, 102, 1);
        plain_frame("run2", 484, 407, 190, 102, 1);
        plain_frame("run3", 676, 407, 190, 102, 1);
        plain_frame("run4", 868, 407, 190, 102, 1);

        frnt_spd = 11'd230;
        plain_frame("drop_hold", 868, 407, 190, 102, 1);
        frame_chk("midchg", 790, 407, 190, 102, 1, 50, 1'b1, 11'd0, -1, 1'b0);
        plain_frame("down1", 598, 407, 190, 102, 1);
        plain_frame("down2", 406, 407, 190, 102, 1);
        plain_frame("down3", 214, 407, 190, 102, 1);
        plain_frame("down4", 100, 407, 190, 102, 1);

        frame_chk("disarm_mid", 100, 407, 190, 102, 1, 500, 1'b0, 11'd0, -1, 1'b0);
        frame_chk("arm_glitch", 100, 107, 100, 102, 0, 200, 1'b1, 11'd0, 600, 1'b0);

        arm = 1'b1;
        idle_frame("rearm_sample", 0);
        idle_frame("rearm1", 0);
        idle_frame("rearm2", 0);
        arm = 1'b0;
        idle_frame("abort", 0);
        arm = 1'b1;
        idle_frame("rearm_again", 0);
        for (int f = 0; f < 4; f++) idle_frame($sformatf("arming_b%0d", f), 0);
        idle_frame("run_b0", 1);
        plain_frame("run_b1", 100, 299, 190, 102, 1);

        #1;
        rst_n = 1'b0;
        #1;
        check("async_rst_outs", int'({frnt, bck, lft, rght, armed, frm_strb}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_first_strobe("reboot");
        idle_frame("post_rst", 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/esc_bank.md
Name: esc_bank

Overview:
- Four-channel ESC pulse generator. It sits directly downstream of the flight controller and consumes its 11-bit unsigned frnt/bck/lft/rght motor speeds.
- Converts each speed to a servo-style PWM pulse, one pulse per fixed frame.
- Adds an arming sequence and a per-frame slew limit, so motors never step from rest to high speed.
- All four channels share one frame counter; speeds are committed only at frame boundaries, so no pulse is ever truncated or glitched.

Parameters:
- PERIOD_W, 17: frame counter width; frame length = 2^PERIOD_W clocks (131072, about 381 Hz at 50 MHz).
- MIN_PULSE, 50000: pulse width in clocks for speed 0 (1.0 ms at 50 MHz).
- ARM_FRAMES, 16: consecutive frames at speed 0 with arm held before entering RUN.
- SLEW, 64: maximum change of applied speed per frame, in speed LSBs.
- OFF_FRNT, OFF_BCK, OFF_LFT, OFF_RGHT, 0: per-motor 10-bit unsigned trim, in clocks, added to that channel's pulse.

Ports:
- clk, input, 1: system clock.
- rst_n, input, 1: reset; asynchronous, active-low.
- arm, input, 1: level request to arm the motors.
- frnt_spd, input, 11: unsigned target speed, front motor.
- bck_spd, input, 11: unsigned target speed, back motor.
- lft_spd, input, 11: unsigned target speed, left motor.
- rght_spd, input, 11: unsigned target speed, right motor.
- frnt, output, 1: PWM output to the front ESC.
- bck, output, 1: PWM output to the back ESC.
- lft, output, 1: PWM output to the left ESC.
- rght, output, 1: PWM output to the right ESC.
- armed, output, 1: high while in RUN.
- frm_strb, output, 1: one-cycle pulse marking the first cycle of each frame.

Behaviour:
- Reset values: cnt=0, state=IDLE, arm_cnt=0, all four applied speeds (app_x) =0. Outputs frnt/bck/lft/rght/armed/frm_strb all 0.
- All outputs are registered.
- Frame counter:
  - cnt free-runs from 0 to 2^PERIOD_W-1 and wraps.
  - frame_end is the cycle where cnt is at its maximum value.
  - frm_strb is high for exactly one cycle per frame, the first cycle of each frame.
  - Frame period = 2^PERIOD_W clocks exactly.
- Pulse width per channel:
  - width_x = MIN_PULSE + 3*app_x + OFF_x, computed in 17+ bits (maximum 50000+6141+1023 = 57164 clocks).
  - A channel output is high for exactly width_x consecutive cycles, starting in the cycle frm_strb is high, and low for the rest of the frame.
  - width_x < 2^PERIOD_W is guaranteed by the parameters; no wrap handling is needed.
- Commit timing:
  - Targets are sampled, and state and app_x are updated, only at frame_end.
  - New values govern the pulse that starts in the next cycle.
  - Input changes mid-frame have no effect on the current pulse.
- State machine, evaluated only at frame_end:
  - IDLE: app_x=0. If arm=1, go to ARMING and set arm_cnt=1; otherwise stay.
  - ARMING: app_x=0. If arm=0, go to IDLE. Else if arm_cnt==ARM_FRAMES, go to RUN. Else increment arm_cnt.
  - RUN: if arm=0, go to IDLE and force app_x=0 immediately, with no slew. Otherwise apply the slew rule per channel.
- Slew rule, per channel, with target t:
  - If |t - app_x| <= SLEW, then app_x = t.
  - Else if t > app_x, then app_x = app_x + SLEW.
  - Else app_x = app_x - SLEW.
  - Use signed 12-bit difference arithmetic; app_x never leaves the range 0..2047.
- armed:
  - Rises in the first cycle of the first RUN frame, together with frm_strb.
  - Falls in the first cycle of the frame after arm is seen low at frame_end.
- Simultaneous events: arm toggling within a frame is invisible; only its value at frame_end matters.
- Reset mid-frame:
  - Outputs go low immediately and asynchronously.
  - After release, cnt restarts at 0 in state IDLE.
  - The first frm_strb occurs after a full wrap, so the first pulse emitted is a complete speed-0 pulse.

Test Plan:
- Reset, then arm=0 for 3 frames → armed=0 throughout. Every pulse is exactly 50000 clocks. frm_strb spacing is 131072 clocks.
- arm=1 with all speeds 11'h400 → pulses stay at 50000 for 16 frames after arm is sampled. armed then rises. The next frames show app stepping 64, 128, …, up to 1024 (pulse 50192, 50384, …, 53072), reaching 1024 after 16 RUN frames.
- In RUN at app=1024, drop target to 1000 → the next frame lands exactly at 1000 (pulse 53000), with no overshoot.
- In RUN at app=2047, deassert arm mid-frame → the current pulse completes at 56141 clocks. The next frame's pulse is 50000 and armed=0. Reasserting arm requires 16 more frames before RUN.
- Drop arm during ARMING at frame 10 → back to IDLE, arm_cnt cleared. A full 16 frames are needed after re-arm.
- Change frnt_spd mid-frame while its pulse is high → the current pulse width is unchanged; the new value takes effect only at the next frame, slew-limited.
